// File: rtl/dout_uart_pkg.sv
// Shared types and constants for the register-to-UART transmitter.
package dout_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module uart_bit_timer
    import dout_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic bit_done_o
);

    localparam int              CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_done_o = enable_i && !clear_i && (cnt_q == TERM);

    // Next count: clear wins, otherwise wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (enable_i)
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dout_uart_tx.sv
// Watches the data-register byte and sends every new value as an 8N1 UART frame.
module dout_uart_tx
    import dout_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       csi_clk,
    input  logic       rsi_reset_n,
    input  logic [7:0] coe_din,
    output logic       coe_tx,
    output logic       coe_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e  state_q;
    logic [7:0] prev_q, hold_q, hold_d, shreg_q;
    logic       pending_q, pending_d;
    logic [2:0] bit_q;
    logic       tx_q, busy_q;
    logic       bit_done, change, consume;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk_i      (csi_clk),
        .rst_ni     (rsi_reset_n),
        .clear_i    (state_q == IDLE),
        .enable_i   (state_q != IDLE),
        .bit_done_o (bit_done)
    );

    assign change  = (coe_din != prev_q);
    // Pending is consumed whenever a frame starts (from IDLE or straight out of STOP).
    assign consume = pending_q && ((state_q == IDLE) || (state_q == STOP && bit_done));

    // A fresh change beats a same-edge consume, so the newest value is never lost.
    always_comb begin
        hold_d    = hold_q;
        pending_d = pending_q;
        if (change) begin
            hold_d    = coe_din;
            pending_d = 1'b1;
        end else if (consume) begin
            pending_d = 1'b0;
        end
    end

    // Change detector and coalescing hold register.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            prev_q    <= 8'h00;
            hold_q    <= 8'h00;
            pending_q <= 1'b0;
        end else begin
            if (change) prev_q <= coe_din;
            hold_q    <= hold_d;
            pending_q <= pending_d;
        end
    end

    // Frame FSM with registered line and busy outputs; new frames load the old hold.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q <= IDLE;
            shreg_q <= 8'h00;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (pending_q) begin
                    state_q <= START;
                    shreg_q <= hold_q;
                    bit_q   <= 3'd0;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
                START: if (bit_done) begin
                    state_q <= DATA;
                    tx_q    <= shreg_q[0];
                end
                DATA: if (bit_done) begin
                    if (bit_q == LAST_BIT) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        shreg_q <= shreg_q >> 1;
                        tx_q    <= shreg_q[1];
                        bit_q   <= bit_q + 3'd1;
                    end
                end
                STOP: if (bit_done) begin
                    if (pending_q) begin
                        state_q <= START;
                        shreg_q <= hold_q;
                        bit_q   <= 3'd0;
                        tx_q    <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coe_tx   = tx_q;
    assign coe_busy = busy_q;

endmodule

// File: tb/tb_dout_uart_tx.sv
// Scoreboard bench: a frame-level model predicts which bytes go out and when;
// a line monitor decodes the UART output and checks against the prediction.
module tb_dout_uart_tx;
    import dout_uart_pkg::*;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx, busy;

    dout_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .csi_clk     (clk),
        .rsi_reset_n (rst_n),
        .coe_din     (din),
        .coe_tx      (tx),
        .coe_busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        int         t;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one frame of FRAME_CYC cycles at a time; a pending byte
    // goes out as soon as the line is free, with the newest value winning.
    int         cyc = 0;
    logic [7:0] m_prev = 8'h00, m_hold = 8'h00;
    bit         m_pend = 1'b0;
    int         m_free = 0;

    task automatic model_clear();
        m_prev = 8'h00; m_hold = 8'h00; m_pend = 1'b0; m_free = 0;
        q.delete();
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_clear();
        end else begin
            if (m_pend && cyc >= m_free) begin
                q.push_back('{d: m_hold, t: cyc});
                m_free = cyc + FRAME_CYC;
                m_pend = 1'b0;
            end
            if (din != m_prev) begin
                m_prev = din;
                m_hold = din;
                m_pend = 1'b1;
            end
        end
    end

    // Line monitor: samples mid-bit, decodes a frame, checks against the queue.
    bit         in_f = 1'b0;
    int         f_start, f_idx;
    logic [9:0] f_bits;
    exp_t       e;

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, (cyc < m_free)});
        if (cyc >= m_free) chk("tx_idle", {31'd0, tx}, 32'd1);
        if (!rst_n) begin
            in_f = 1'b0;
        end else begin
            if (!in_f && tx == 1'b0) begin
                in_f = 1'b1; f_start = cyc; f_idx = 0;
            end
            if (in_f) begin
                if (f_idx % CPB == CPB / 2) f_bits[f_idx / CPB] = tx;
                if (f_idx == FRAME_CYC - 1) begin
                    in_f = 1'b0;
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_frame: got byte %0h, none expected", f_bits[8:1]);
                    end else begin
                        e = q.pop_front();
                        chk("start_bit", {31'd0, f_bits[0]}, 32'd0);
                        chk("stop_bit", {31'd0, f_bits[9]}, 32'd1);
                        chk("data", {24'd0, f_bits[8:1]}, {24'd0, e.d});
                        chk("start_cycle", f_start, e.t);
                    end
                end
                f_idx++;
            end
        end
    end

    // Advance n edges, then drive inputs safely away from the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin
        // Reset and quiet line
        rst_n = 1'b0; din = 8'h00;
        step(3);
        rst_n = 1'b1;
        step(200);
        chk("no_frame_after_reset", q.size(), 0);

        // Single byte
        din = 8'hA5; step(60);

        // Coalescing: 0x11 then 0x33
        din = 8'h11; step(10);
        din = 8'h22; step(10);
        din = 8'h33; step(100);

        // Revert within a frame: 0x00, 0x33, 0x33
        din = 8'h00; step(10);
        din = 8'h33; step(60);
        din = 8'h44; step(1);
        din = 8'h33; step(100);

        // Change on the edge that leaves IDLE
        din = 8'h5A; step(1);
        din = 8'h0F; step(100);

        // Reset in the middle of data bit 3
        din = 8'hC3;
        for (int i = 0; i < 10 && q.size() == 0; i++) step(1);
        chk("c3_frame_started", {31'd0, (q.size() != 0)}, 32'd1);
        step(17);
        rst_n = 1'b0;
        #1;
        chk("async_tx", {31'd0, tx}, 32'd1);
        chk("async_busy", {31'd0, busy}, 32'd0);
        model_clear();
        din = 8'h7E;
        step(2);
        rst_n = 1'b1;
        step(100);

        // Randomized change stream
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) din = 8'($urandom);
            step(1);
        end
        step(2 * FRAME_CYC + 10);
        chk("all_frames_seen", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dout_uart_tx.md
# dout_uart_tx

Downstream consumer of the 8-bit Avalon slave data register output (`coe_s0_Dout`). It watches the byte for changes and serialises each new value onto a UART TX line: 8N1 framing, LSB first, fixed bit period. It is the stage that makes the register-written byte externally observable. It needs no software handshake: a write that changes the register value produces a frame.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range 2..65535.
- `csi_clk`  in  1  sole clock; all state on rising edge.
- `rsi_reset_n`  in  1  asynchronous, active-low reset.
- `coe_din`  in  8  byte to transmit; connected to the slave's `coe_s0_Dout`; synchronous to `csi_clk`.
- `coe_tx`  out  1  UART serial line, idle high.
- `coe_busy`  out  1  high while a frame (start..stop) is on the line.

## Operation
- Reset values (asserted asynchronously):
  - `coe_tx`=1, `coe_busy`=0
  - state=IDLE
  - `prev`=0x00, `hold`=0x00, `pending`=0, bit counter=0, baud counter=0.
- Change detect, every edge:
  - If `coe_din`≠`prev`: `prev`<=`coe_din`, `hold`<=`coe_din`, `pending`<=1.
  - `prev` reset value 0x00 equals the slave's reset value, so no frame is sent after reset.
- Coalescing: changes during a frame overwrite `hold`. Only the most recent value is sent after the current frame. A→B→A within one frame still sets `pending` and sends A.
- FSM states:
  - IDLE: `coe_tx`=1. If `pending`: go to START, load shift register from `hold`, clear `pending`.
  - START: `coe_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `coe_tx`=shreg[0]. Shift right each bit period; 8 bits, counter 0..7. After bit 7, go to STOP.
  - STOP: `coe_tx`=1 for CLKS_PER_BIT cycles. At the end: if `pending`, go directly to START and load `hold` (no idle gap); otherwise go to IDLE.
- Simultaneous events:
  - A change detected on the same edge that consumes `pending` (IDLE→START or STOP→START) wins: `pending` stays 1 and `hold` takes the new value.
  - The frame that just started carries the old `hold`.
- `coe_busy` is 1 in START/DATA/STOP and 0 in IDLE. It is registered with the state.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps; a bit ends on the terminal count. It is cleared on every state entry from IDLE.
- Reset mid-frame: line returns high immediately (async), the frame is aborted and not resumed. After release, a `coe_din`≠0 is treated as a change and sent.

## Timing
- `coe_din` changes before edge k → `pending` set at k → `coe_tx` falls after edge k+1. Latency is 2 edges.
- Frame length is exactly 10×CLKS_PER_BIT cycles: start, d0..d7, stop.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- All outputs are registered (no combinational path from `coe_din` to `coe_tx`). Single clock domain, no CDC.

## Structure
- Package `dout_uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e`
  - `localparam int DATA_BITS = 8`
  - `localparam int FRAME_BITS = 10`
- Sub-module `uart_bit_timer`:
  - Parameterised by CLKS_PER_BIT; inputs clear/enable.
  - Outputs one-cycle `bit_done` on terminal count.
  - Same clock and reset as the top.
- Top holds the change detector, `hold`/`pending`, shift register and FSM.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: `rsi_reset_n`=0 for 3 cycles, `coe_din`=0x00 for 200 cycles → `coe_tx`=1 and `coe_busy`=0 throughout; no frame.
- Single byte: `coe_din` 0x00→0xA5 before edge k → `coe_tx` falls after k+1. Line sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `coe_busy` high exactly 40 cycles.
- Coalescing: 0x11, then 0x22 and 0x33 during the 0x11 frame → exactly two frames, 0x11 then 0x33, contiguous (no idle cycle between them). `coe_busy` stays high 80 cycles.
- Revert: during a 0x33 frame, `coe_din`=0x44 for 1 cycle then back to 0x33 → a second 0x33 frame follows.
- Boundary: `coe_din` changes to 0x0F on the edge the FSM leaves IDLE for 0x5A → frames 0x5A then 0x0F, back-to-back.
- Reset mid-frame: assert reset during d3 of 0xC3 → `coe_tx`=1 and `coe_busy`=0 without waiting for a clock edge. Release with `coe_din`=0x7E → one 0x7E frame starts 2 edges after release.
